// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pong_pkg
// Brief    : Shared state encoding, score width and winner codes for the
//            Pong game controller.
// Revision : 1.0
// ============================================================================
package pong_pkg;

    localparam int c_SCORE_W = 4;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SERVE = 3'd1;
    localparam logic [2:0] c_ST_PLAY  = 3'd2;
    localparam logic [2:0] c_ST_PAUSE = 3'd3;
    localparam logic [2:0] c_ST_OVER  = 3'd4;

    localparam logic [1:0] c_WIN_NONE = 2'd0;
    localparam logic [1:0] c_WIN_P1   = 2'd1;
    localparam logic [1:0] c_WIN_P2   = 2'd2;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pong_game_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pong_game_ctrl_if
// Brief    : Player/timer inputs and game-state outputs of the controller.
// Revision : 1.0
// ============================================================================
interface pong_game_ctrl_if #(
    parameter int XW = 10,
    parameter int YW = 9
);
    logic          frame_tick;
    logic          start;
    logic          pause;
    logic          up1;
    logic          down1;
    logic          up2;
    logic          down2;
    logic [3:0]    sec1;
    logic [XW-1:0] ball_x;
    logic [YW-1:0] ball_y;
    logic [YW-1:0] paddle1;
    logic [YW-1:0] paddle2;
    logic [3:0]    score1;
    logic [3:0]    score2;
    logic [2:0]    state;
    logic [1:0]    winner;

    modport master (
        output frame_tick, start, pause, up1, down1, up2, down2, sec1,
        input  ball_x, ball_y, paddle1, paddle2, score1, score2, state, winner
    );

    modport slave (
        input  frame_tick, start, pause, up1, down1, up2, down2, sec1,
        output ball_x, ball_y, paddle1, paddle2, score1, score2, state, winner
    );
endinterface
`default_nettype wire

// File: rtl/pong_paddle.sv
`default_nettype none
// ============================================================================
// Module   : pong_paddle
// Brief    : One paddle: steps per enabled frame tick, clamped to the screen.
// Revision : 1.0
// ============================================================================
module pong_paddle #(
    parameter int V_RES       = 480,
    parameter int PADDLE_H    = 64,
    parameter int PADDLE_STEP = 4,
    parameter int YW          = 9
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          frame_tick,
    input  wire logic          enable,
    input  wire logic          center,
    input  wire logic          up,
    input  wire logic          down,
    output logic [YW-1:0]      y
);
    localparam int c_Y_MAX = V_RES - PADDLE_H;
    localparam int c_Y_MID = (V_RES - PADDLE_H) / 2;

    logic [YW-1:0] r_y;
    logic [YW-1:0] w_y_next;

    // Both buttons held cancel out.
    always_comb begin
        w_y_next = r_y;
        if (up && !down) begin
            w_y_next = (int'(r_y) < PADDLE_STEP) ? '0 : r_y - YW'(PADDLE_STEP);
        end else if (down && !up) begin
            w_y_next = (int'(r_y) + PADDLE_STEP > c_Y_MAX) ? YW'(c_Y_MAX)
                                                           : r_y + YW'(PADDLE_STEP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y <= YW'(c_Y_MID);
        end else if (center) begin
            r_y <= YW'(c_Y_MID);
        end else if (frame_tick && enable) begin
            r_y <= w_y_next;
        end
    end

    assign y = r_y;

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pong_game_ctrl
// Brief    : Pong game FSM, ball kinematics, scoring and win detection.
// Revision : 1.0
// ============================================================================
module pong_game_ctrl #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_W     = 8,
    parameter int BALL_SZ      = 8,
    parameter int P1_X         = 16,
    parameter int P2_X         = 616,
    parameter int PADDLE_STEP  = 4,
    parameter int BASE_SPEED   = 2,
    parameter int MAX_SPEED    = 6,
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    pong_game_ctrl_if.slave  bus
);
    import pong_pkg::*;

    localparam int XW      = $clog2(H_RES);
    localparam int YW      = $clog2(V_RES);
    localparam int c_BX_MID = (H_RES - BALL_SZ) / 2;
    localparam int c_BY_MID = (V_RES - BALL_SZ) / 2;
    localparam int c_BX_MAX = H_RES - BALL_SZ;
    localparam int c_BY_MAX = V_RES - BALL_SZ;
    localparam int c_CNT_W  = $clog2(SERVE_FRAMES + 1);

    logic                 r_start_d, r_start_q, r_pause_d, r_pause_q;
    logic [2:0]           r_state;
    logic [XW-1:0]        r_ball_x;
    logic [YW-1:0]        r_ball_y;
    logic                 r_dx_right, r_dy_down;
    logic [c_SCORE_W-1:0] r_score1, r_score2;
    logic [1:0]           r_winner;
    logic [c_CNT_W-1:0]   r_serve_cnt;

    logic          w_start_edge, w_pause_edge, w_pause_ok, w_pad_en;
    logic [YW-1:0] w_paddle1, w_paddle2;
    int            w_spd, w_bx, w_by, w_nx, w_ny, w_p1, w_p2;
    logic          w_ndx, w_ndy, w_hit1, w_hit2, w_miss1, w_miss2;

    assign w_start_edge = r_start_d & ~r_start_q;
    assign w_pause_edge = r_pause_d & ~r_pause_q;
    assign w_pause_ok   = w_pause_edge && (r_state == c_ST_PLAY || r_state == c_ST_PAUSE);
    assign w_pad_en     = !w_start_edge && !w_pause_ok &&
                          (r_state == c_ST_SERVE || r_state == c_ST_PLAY);

    pong_paddle #(
        .V_RES(V_RES), .PADDLE_H(PADDLE_H), .PADDLE_STEP(PADDLE_STEP), .YW(YW)
    ) u_paddle1 (
        .clk(clk), .rst_n(rst_n), .frame_tick(bus.frame_tick), .enable(w_pad_en),
        .center(w_start_edge), .up(bus.up1), .down(bus.down1), .y(w_paddle1)
    );

    pong_paddle #(
        .V_RES(V_RES), .PADDLE_H(PADDLE_H), .PADDLE_STEP(PADDLE_STEP), .YW(YW)
    ) u_paddle2 (
        .clk(clk), .rst_n(rst_n), .frame_tick(bus.frame_tick), .enable(w_pad_en),
        .center(w_start_edge), .up(bus.up2), .down(bus.down2), .y(w_paddle2)
    );

    // Ball step uses the paddle positions held before this tick's paddle update.
    always_comb begin
        w_spd   = min_int(BASE_SPEED + int'(bus.sec1), MAX_SPEED);
        w_bx    = int'(r_ball_x);
        w_by    = int'(r_ball_y);
        w_p1    = int'(w_paddle1);
        w_p2    = int'(w_paddle2);
        w_ny    = w_by;
        w_ndy   = r_dy_down;
        w_nx    = w_bx;
        w_ndx   = r_dx_right;
        w_miss1 = 1'b0;
        w_miss2 = 1'b0;

        if (!r_dy_down) begin
            if (w_by < w_spd) begin
                w_ny  = 0;
                w_ndy = 1'b1;
            end else begin
                w_ny  = w_by - w_spd;
            end
        end else if (w_by + w_spd > c_BY_MAX) begin
            w_ny  = c_BY_MAX;
            w_ndy = 1'b0;
        end else begin
            w_ny  = w_by + w_spd;
        end

        w_hit1 = !r_dx_right && (w_bx - w_spd <= P1_X + PADDLE_W) && (w_bx >= P1_X) &&
                 (w_by + BALL_SZ > w_p1) && (w_by < w_p1 + PADDLE_H);
        w_hit2 = r_dx_right && (w_bx + w_spd + BALL_SZ >= P2_X) &&
                 (w_bx + BALL_SZ <= P2_X + PADDLE_W) &&
                 (w_by + BALL_SZ > w_p2) && (w_by < w_p2 + PADDLE_H);

        if (w_hit1) begin
            w_nx  = P1_X + PADDLE_W;
            w_ndx = 1'b1;
        end else if (w_hit2) begin
            w_nx  = P2_X - BALL_SZ;
            w_ndx = 1'b0;
        end else if (!r_dx_right && w_bx < w_spd) begin
            w_miss1 = 1'b1;
        end else if (r_dx_right && w_bx + w_spd > c_BX_MAX) begin
            w_miss2 = 1'b1;
        end else begin
            w_nx = r_dx_right ? w_bx + w_spd : w_bx - w_spd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_d   <= 1'b0;
            r_start_q   <= 1'b0;
            r_pause_d   <= 1'b0;
            r_pause_q   <= 1'b0;
            r_state     <= c_ST_IDLE;
            r_ball_x    <= XW'(c_BX_MID);
            r_ball_y    <= YW'(c_BY_MID);
            r_dx_right  <= 1'b1;
            r_dy_down   <= 1'b1;
            r_score1    <= '0;
            r_score2    <= '0;
            r_winner    <= c_WIN_NONE;
            r_serve_cnt <= '0;
        end else begin
            r_start_d <= bus.start;
            r_start_q <= r_start_d;
            r_pause_d <= bus.pause;
            r_pause_q <= r_pause_d;

            if (w_start_edge) begin
                r_state     <= c_ST_SERVE;
                r_ball_x    <= XW'(c_BX_MID);
                r_ball_y    <= YW'(c_BY_MID);
                r_dx_right  <= 1'b1;
                r_dy_down   <= 1'b1;
                r_score1    <= '0;
                r_score2    <= '0;
                r_winner    <= c_WIN_NONE;
                r_serve_cnt <= '0;
            end else if (w_pause_ok) begin
                r_state <= (r_state == c_ST_PLAY) ? c_ST_PAUSE : c_ST_PLAY;
            end else if (bus.frame_tick) begin
                case (r_state)
                    c_ST_SERVE: begin
                        if (r_serve_cnt == c_CNT_W'(SERVE_FRAMES - 1)) begin
                            r_state     <= c_ST_PLAY;
                            r_serve_cnt <= '0;
                        end else begin
                            r_serve_cnt <= r_serve_cnt + c_CNT_W'(1);
                        end
                    end
                    c_ST_PLAY: begin
                        r_dy_down <= w_ndy;
                        if (w_miss1 || w_miss2) begin
                            // Serve goes toward whoever just conceded.
                            r_ball_x    <= XW'(c_BX_MID);
                            r_ball_y    <= YW'(c_BY_MID);
                            r_dx_right  <= w_miss2;
                            r_serve_cnt <= '0;
                            r_state     <= c_ST_SERVE;
                            if (w_miss1) begin
                                r_score2 <= r_score2 + c_SCORE_W'(1);
                                if (int'(r_score2) + 1 == WIN_SCORE) begin
                                    r_state  <= c_ST_OVER;
                                    r_winner <= c_WIN_P2;
                                end
                            end else begin
                                r_score1 <= r_score1 + c_SCORE_W'(1);
                                if (int'(r_score1) + 1 == WIN_SCORE) begin
                                    r_state  <= c_ST_OVER;
                                    r_winner <= c_WIN_P1;
                                end
                            end
                        end else begin
                            r_ball_x   <= XW'(w_nx);
                            r_ball_y   <= YW'(w_ny);
                            r_dx_right <= w_ndx;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.ball_x  = r_ball_x;
    assign bus.ball_y  = r_ball_y;
    assign bus.paddle1 = w_paddle1;
    assign bus.paddle2 = w_paddle2;
    assign bus.score1  = r_score1;
    assign bus.score2  = r_score2;
    assign bus.state   = r_state;
    assign bus.winner  = r_winner;

endmodule
`default_nettype wire

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Parametrised Pong game controller: owns the game state machine, ball kinematics, paddle positions, score and win detection for two players. It sits between the debounced button/timer inputs and the VGA renderer and advances the game once per frame tick. It adds to the earlier fixed-size controller: configurable screen and sprite geometry, speed ramp driven by elapsed time, a serve delay, a pause mode and first-to-N scoring.

## Interface
- H_RES, 640, screen width in pixels; XW = $clog2(H_RES)
- V_RES, 480, screen height in pixels; YW = $clog2(V_RES)
- PADDLE_H, 64, paddle height; PADDLE_W, 8, paddle width
- BALL_SZ, 8, ball square side
- P1_X, 16 / P2_X, 616, fixed left x of paddle 1 / paddle 2
- PADDLE_STEP, 4, paddle pixels per frame
- BASE_SPEED, 2 / MAX_SPEED, 6, ball pixels per frame per axis
- WIN_SCORE, 7, points to win (≤15)
- SERVE_FRAMES, 60, frames ball is held before a serve
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- frame_tick  in  1  one-cycle pulse per video frame
- start  in  1  level; rising edge starts/restarts
- pause  in  1  level; rising edge toggles pause
- up1, down1, up2, down2  in  1 each  paddle controls, level
- sec1  in  4  tens digit of game seconds
- ball_x  out  XW / ball_y  out  YW  ball top-left
- paddle1, paddle2  out  YW  paddle top y
- score1, score2  out  4  points
- state  out  3  current state
- winner  out  2  0 none, 1 player 1, 2 player 2

## Operation
- States: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4.
- Reset: state IDLE; ball at ((H_RES-BALL_SZ)/2, (V_RES-BALL_SZ)/2); paddles at (V_RES-PADDLE_H)/2; scores 0; winner 0; direction dx=+ (right), dy=+ (down); serve counter 0.
- start/pause edges: registered copies; edge = in & ~in_q.
- IDLE: start edge → SERVE, scores/winner cleared, ball and paddles centred, counter cleared.
- SERVE: ball held at centre; paddles move; counter increments on frame_tick; at SERVE_FRAMES-th tick → PLAY.
- PLAY, per frame_tick: paddles move, then ball steps by spd = min(BASE_SPEED + sec1, MAX_SPEED) on each axis.
- Vertical: moving up with y < spd → y=0, dy=+; moving down with y+spd > V_RES-BALL_SZ → y=V_RES-BALL_SZ, dy=−; else y ± spd.
- Paddle 1 hit (checked first): dx=− and x−spd ≤ P1_X+PADDLE_W and x ≥ P1_X and ball_y+BALL_SZ > paddle1 and ball_y < paddle1+PADDLE_H → x=P1_X+PADDLE_W, dx=+. Paddle 2 mirror: x+spd+BALL_SZ ≥ P2_X → x=P2_X−BALL_SZ, dx=−.
- Miss: dx=− and x < spd → score2+1; dx=+ and x+spd > H_RES−BALL_SZ → score1+1. Ball recentred, dx toward the player who conceded, → SERVE; if new score = WIN_SCORE → OVER, winner set, ball centred.
- Corner: vertical and horizontal reflection in same tick both apply.
- Paddles: only on frame_tick in SERVE/PLAY; up&down both set → no move; clamp to [0, V_RES−PADDLE_H].
- PAUSE: pause edge in PLAY → PAUSE; pause edge in PAUSE → PLAY; nothing moves while paused; start edge in PAUSE → IDLE reset behaviour then SERVE.
- OVER: outputs frozen; start edge → SERVE as from IDLE.
- Priority in one cycle: reset > start edge > pause edge > frame_tick.

## Timing
- All outputs registered; state/position change visible one clk after the sampling edge of frame_tick or detected edge.
- Edge detect adds one cycle: start high at cycle n → state changes at n+2.
- Serve: exactly SERVE_FRAMES frame_ticks between entering SERVE and first ball move (move on tick SERVE_FRAMES+1).
- Asynchronous reset mid-frame returns all outputs to reset values immediately; no partial update survives.

## Structure
- Package pong_pkg: state encoding, score width, winner codes.
- Sub-module pong_paddle (instantiated twice): up/down/frame_tick/enable in, clamped y out.

## Test plan
- Reset, start edge → state SERVE two cycles later; 60 ticks later PLAY; ball (316,236) → (318,238) on next tick with sec1=0.
- Paddle: up1 held 200 ticks from 208 → paddle1 stops at 0; up1&down1 → unchanged.
- Ball y=2 moving up, spd=4 → y=0, dy=+; corner hit reflects both axes.
- Ball moving left aligned with paddle1=200, ball_y=220 → bounces to x=24; paddle1=0 instead → score2=1, state SERVE, dx=−.
- score1=6, miss by player 2 → score1=7, state OVER, winner=1; start edge → scores 0, SERVE.
- sec1=9 → spd=6; pause edge in PLAY freezes ball across 10 ticks, second edge resumes.
